// File: rtl/pc_sequencer.sv
// Next-PC sequencer and IF/ID hazard controller for the five-stage MIPS pipeline.
// Selects the next fetch address and drives PC hold, IF/ID hold/flush and ID/EX bubble.
// Optional build macro PC_SEQ_STALL_CNT_EN adds saturating stall/flush event counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
`ifdef PC_SEQ_STALL_CNT_EN
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`else
  output logic [1:0]  state
`endif
);

  localparam logic [1:0] BOOT       = 2'd0;
  localparam logic [1:0] RUN        = 2'd1;
  localparam logic [1:0] IM_WAIT    = 2'd2;
  localparam logic [1:0] REDIR_WAIT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] redir_q, redir_d;
  logic        redir_v, redir_v_d;
  logic        lu;
  logic        redir;
  logic [31:0] redir_tgt;

  assign state = state_q;

  // Hazard detection and redirect target selection (jr > jmp > branch).
  always_comb begin
    lu = ex_mem_read && (ex_rt != 5'd0) &&
         ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    redir = jr || jmp || br_taken;
    if (jr) begin
      redir_tgt = jr_target;
    end else if (jmp) begin
      redir_tgt = jmp_target;
    end else begin
      redir_tgt = br_target;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    pc_next     = pc_cur + 32'd4;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    redir_d     = redir_q;
    redir_v_d   = redir_v;
    case (state_q)
      BOOT: begin
        pc_next     = RESET_VECTOR;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_d     = RUN;
      end
      RUN, IM_WAIT: begin
        if (lu) begin
          // ID operands are stale, so any redirect request is ignored this cycle.
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end else if (redir && imem_ready) begin
          pc_next    = redir_tgt;
          ifid_flush = 1'b1;
          state_d    = RUN;
        end else if (redir) begin
          // Fetch still pending: remember where to go once it completes.
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          redir_d    = redir_tgt;
          redir_v_d  = 1'b1;
          state_d    = REDIR_WAIT;
        end else if (!imem_ready) begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          state_d    = IM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        // REDIR_WAIT: the pending fetch is wrong-path and is discarded on arrival.
        ifid_flush = 1'b1;
        if (imem_ready && redir_v) begin
          pc_next   = redir_q;
          redir_v_d = 1'b0;
          state_d   = RUN;
        end else begin
          pc_hold = 1'b1;
        end
      end
    endcase
  end

  // FSM and latched redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      redir_q <= 32'd0;
      redir_v <= 1'b0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      redir_v <= redir_v_d;
    end
  end

`ifdef PC_SEQ_STALL_CNT_EN
  // Saturating stall/flush event counters, BOOT cycles excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (state_q != BOOT) begin
      if (pc_hold && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan steps then randomized cycles,
// all checked against a behavioural reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_mem_read;
  logic        br_taken, jmp, jr;
  logic [31:0] br_target, jmp_target, jr_target;
  logic [31:0] pc_next;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [1:0]  state;
`ifdef PC_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Model: booting flag, instruction-memory wait flag, pending redirect targets.
  bit          m_boot;
  bit          m_wait;
  logic [31:0] m_pend[$];

  typedef struct {
    logic [31:0] pc_next;
    logic        hold, ihold, flush, bub;
    logic [1:0]  st;
    bit          n_wait, push, pop;
    logic [31:0] tgt;
  } exp_t;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .jr(jr), .jr_target(jr_target),
    .pc_next(pc_next), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
`ifdef PC_SEQ_STALL_CNT_EN
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .state(state)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_wait = 1'b0;
    m_pend.delete();
`ifdef PC_SEQ_STALL_CNT_EN
    m_stall = 32'd0;
    m_flush = 32'd0;
`endif
  endtask

  function automatic exp_t model_eval();
    exp_t e;
    bit   hit;
    logic [31:0] tgt;
    e.pc_next = pc_cur + 32'd4;
    e.hold = 0; e.ihold = 0; e.flush = 0; e.bub = 0;
    e.n_wait = m_wait; e.push = 0; e.pop = 0; e.tgt = 32'd0;
    hit = ex_mem_read && ex_rt != 0 &&
          ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    tgt = jr ? jr_target : (jmp ? jmp_target : br_target);
    if (m_boot) begin
      e.pc_next = RV; e.flush = 1; e.bub = 1; e.n_wait = 0;
    end else if (m_pend.size() != 0) begin
      e.flush = 1;
      if (imem_ready) begin
        e.pc_next = m_pend[0]; e.pop = 1; e.n_wait = 0;
      end else begin
        e.hold = 1;
      end
    end else if (hit) begin
      e.hold = 1; e.ihold = 1; e.bub = 1;
    end else if (jr || jmp || br_taken) begin
      e.flush = 1; e.n_wait = 0;
      if (imem_ready) e.pc_next = tgt;
      else begin
        e.hold = 1; e.push = 1; e.tgt = tgt;
      end
    end else if (!imem_ready) begin
      e.hold = 1; e.flush = 1; e.n_wait = 1;
    end else begin
      e.n_wait = 0;
    end
    e.st = m_boot ? 2'd0 : (m_pend.size() != 0 ? 2'd3 : (m_wait ? 2'd2 : 2'd1));
    return e;
  endfunction

  // One clock: check outputs before the edge, advance model and PC register after it.
  task automatic tick();
    exp_t e;
    #3;
    if (!rst_n) model_reset();
    e = model_eval();
    chk("pc_next", pc_next, e.pc_next);
    chk("pc_hold", {31'd0, pc_hold}, {31'd0, e.hold});
    chk("ifid_hold", {31'd0, ifid_hold}, {31'd0, e.ihold});
    chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.flush});
    chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, e.bub});
    chk("state", {30'd0, state}, {30'd0, e.st});
`ifdef PC_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
    @(posedge clk);
    if (rst_n) begin
`ifdef PC_SEQ_STALL_CNT_EN
      if (!m_boot && e.hold && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (!m_boot && e.flush && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
      m_boot = 1'b0;
      m_wait = e.n_wait;
      if (e.pop) void'(m_pend.pop_front());
      if (e.push) m_pend.push_back(e.tgt);
    end
    if (!e.hold) pc_cur = e.pc_next;
    #1;
  endtask

  task automatic quiet();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = 0;
    br_taken = 0; jmp = 0; jr = 0;
    br_target = 0; jmp_target = 0; jr_target = 0;
    imem_ready = 1;
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    pc_cur = 32'h1234_5678;
    model_reset();
    #1;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pc_next", pc_next, RV);
    chk("rst_flush", {31'd0, ifid_flush}, 32'd1);
    chk("rst_bubble", {31'd0, idex_bubble}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset release: 40, 44, 48, 4C.
    tick();
    chk("boot_pc", pc_cur, 32'h40);
    tick(); tick(); tick();
    chk("seq_pc", pc_cur, 32'h4C);
    chk("run_noflush", {31'd0, ifid_flush}, 32'd0);
    tick();

    // Load-use stall at 0x50.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    #1 chk("lu_hold", {31'd0, pc_hold}, 32'd1);
    tick();
    chk("lu_frozen", pc_cur, 32'h50);
    quiet();
    #1 chk("lu_after", pc_next, 32'h54);
    tick();
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
    #1 chk("lu_r0", {31'd0, pc_hold}, 32'd0);
    tick();
    quiet();

    // jr and branch together: jr wins.
    jr = 1; jr_target = 32'h200; br_taken = 1; br_target = 32'h100;
    #1 chk("jr_prio", pc_next, 32'h200);
    tick();
    quiet();
    #1 chk("jr_one_flush", {31'd0, ifid_flush}, 32'd0);
    tick();

    // Instruction-memory wait at 0x80.
    pc_cur = 32'h80;
    imem_ready = 0;
    tick(); tick(); tick();
    chk("imw_state", {30'd0, state}, 32'd2);
    imem_ready = 1;
    #1 chk("imw_resume", pc_next, 32'h84);
    tick();

    // Jump while fetch pending.
    jmp = 1; jmp_target = 32'h400; imem_ready = 0;
    tick();
    jmp = 0;
    #1 chk("rw_state", {30'd0, state}, 32'd3);
    tick();
    imem_ready = 1;
    #1 chk("rw_target", pc_next, 32'h400);
    tick();

    // Reset inside REDIR_WAIT discards the latched target.
    jmp = 1; jmp_target = 32'h800; imem_ready = 0;
    tick();
    quiet();
    imem_ready = 0;
    rst_n = 1'b0;
    #1 chk("rw_rst_state", {30'd0, state}, 32'd0);
    chk("rw_rst_pc", pc_next, RV);
    tick();
    rst_n = 1'b1;
    imem_ready = 1;
    tick();
    #1 chk("rw_rst_discard", pc_next, RV + 32'd4);
    tick();

    // Wrap-around.
    pc_cur = 32'hFFFF_FFFC;
    #1 chk("wrap", pc_next, 32'h0);
    tick();

    // Randomized cycles.
    for (int i = 0; i < 600; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_mem_read = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      br_taken = ($urandom_range(0, 6) == 0);
      jmp = ($urandom_range(0, 6) == 0);
      jr = ($urandom_range(0, 6) == 0);
      br_target = $urandom & 32'hFFFF_FFFC;
      jmp_target = $urandom & 32'hFFFF_FFFC;
      jr_target = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) pc_cur = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 39) == 0) pc_cur = 32'hFFFF_FFFC;
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
